// File: rtl/immgen_pkg.sv
// Shared types, opcode constants and the XLEN-agnostic immediate decoder.
// Define IMMGEN_FP_EN to treat the FP load/store/arith opcodes as legal.
package immgen_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FLOAD     = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_FSTORE    = 7'b0100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_FMADD     = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB     = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef struct packed {
        logic [63:0] imm;
        imm_fmt_t    fmt;
        logic        illegal;
    } imm_dec_t;

    // Immediates are always built at 64 bits; narrower users keep the low bits,
    // which are identical to a native narrow sign/zero extension.
    function automatic imm_dec_t imm_decode(input logic [31:0] instr, input logic xlen64);
        imm_dec_t r;
        r.imm     = 64'd0;
        r.fmt     = FMT_R;
        r.illegal = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: begin
                r.imm = {{52{instr[31]}}, instr[31:20]};
                r.fmt = FMT_I;
            end
            OPC_STORE: begin
                r.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                r.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                r.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                r.fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                r.imm = {{32{instr[31]}}, instr[31:12], 12'd0};
                r.fmt = FMT_U;
            end
            OPC_JAL: begin
                r.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                r.fmt = FMT_J;
            end
            OPC_SYSTEM: begin
                if (instr[14]) begin
                    r.imm = {59'd0, instr[19:15]};
                    r.fmt = FMT_Z;
                end else begin
                    r.imm = {52'd0, instr[31:20]};
                    r.fmt = FMT_I;
                end
            end
            OPC_OP: begin
                r.fmt = FMT_R;
            end
            OPC_OP_IMM_32: begin
                if (xlen64) begin
                    r.imm = {{52{instr[31]}}, instr[31:20]};
                    r.fmt = FMT_I;
                end else begin
                    r.illegal = 1'b1;
                end
            end
`ifdef IMMGEN_FP_EN
            OPC_FLOAD: begin
                r.imm = {{52{instr[31]}}, instr[31:20]};
                r.fmt = FMT_I;
            end
            OPC_FSTORE: begin
                r.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                r.fmt = FMT_S;
            end
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD, OPC_OP_FP: begin
                r.fmt = FMT_R;
            end
`endif
            default: begin
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational immediate decoder sized to XLEN (32 or 64).
// FP opcode legality follows IMMGEN_FP_EN through immgen_pkg.
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_t        o_fmt,
    output logic            o_illegal
);

    localparam logic XLEN64 = (XLEN == 64);

    imm_dec_t w_dec;

    assign w_dec     = imm_decode(i_instr, XLEN64);
    assign o_imm     = w_dec.imm[XLEN-1:0];
    assign o_fmt     = w_dec.fmt;
    assign o_illegal = w_dec.illegal;

    generate
        if (XLEN < 64) begin : g_narrow
            logic w_unused_hi;
            assign w_unused_hi = ^w_dec.imm[63:XLEN];
        end
    endgenerate

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator: decode at the input, one output register
// plus one skid register, valid/ready on both sides, flush on redirect.
// Optional IMMGEN_FP_EN makes FP opcodes legal (see immgen_pkg).
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Payload layout: {imm, fmt, illegal, tag}; all-zero is the reset value.
    localparam int PW = XLEN + 3 + 1 + TAG_W;

    logic [XLEN-1:0] w_dec_imm;
    imm_fmt_t        w_dec_fmt;
    logic            w_dec_illegal;
    logic [PW-1:0]   w_in_pl;

    logic            r_out_valid;
    logic [PW-1:0]   r_out_pl;
    logic            r_skid_valid;
    logic [PW-1:0]   r_skid_pl;
    logic            r_in_ready;

    logic            w_in_fire;
    logic            w_out_free;
    logic            w_out_valid_nx;
    logic [PW-1:0]   w_out_pl_nx;
    logic            w_skid_valid_nx;
    logic [PW-1:0]   w_skid_pl_nx;

    immgen_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    assign w_in_pl    = {w_dec_imm, w_dec_fmt, w_dec_illegal, in_tag};
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    // Next-state selection for output and skid registers; flush wins over loads.
    always_comb begin
        w_out_valid_nx  = r_out_valid;
        w_out_pl_nx     = r_out_pl;
        w_skid_valid_nx = r_skid_valid;
        w_skid_pl_nx    = r_skid_pl;
        if (flush) begin
            w_out_valid_nx  = 1'b0;
            w_skid_valid_nx = 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so only the skid entry can move forward
            if (w_out_free) begin
                w_out_valid_nx  = 1'b1;
                w_out_pl_nx     = r_skid_pl;
                w_skid_valid_nx = 1'b0;
            end else begin
                w_skid_valid_nx = 1'b1;
            end
        end else if (w_in_fire) begin
            if (w_out_free) begin
                w_out_valid_nx = 1'b1;
                w_out_pl_nx    = w_in_pl;
            end else begin
                w_skid_valid_nx = 1'b1;
                w_skid_pl_nx    = w_in_pl;
            end
        end else if (r_out_valid & out_ready) begin
            w_out_valid_nx = 1'b0;
        end else begin
            w_out_valid_nx = r_out_valid;
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_pl     <= {PW{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_pl    <= {PW{1'b0}};
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nx;
            r_out_pl     <= w_out_pl_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_skid_pl    <= w_skid_pl_nx;
            r_in_ready   <= ~w_skid_valid_nx;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_pl[PW-1 -: XLEN];
    assign out_fmt     = r_out_pl[TAG_W+3 -: 3];
    assign out_illegal = r_out_pl[TAG_W];
    assign out_tag     = r_out_pl[TAG_W-1:0];

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32,  out_valid32,  out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic        in_ready64,  out_valid64,  out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] R = 3'd0, I = 3'd1, S = 3'd2, B = 3'd3, U = 3'd4, J = 3'd5, Z = 3'd6;

    immgen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with out_ready=1 and check both outputs a cycle later.
    task automatic send_chk(input string name, input logic [31:0] instr, input logic [7:0] tag,
                            input logic [31:0] e_imm32, input logic [63:0] e_imm64,
                            input logic [2:0] e_fmt32, input logic [2:0] e_fmt64,
                            input logic e_ill32, input logic e_ill64);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_tag    = tag;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({name, ".v32"},   {63'd0, out_valid32},   64'd1);
        chk({name, ".imm32"}, {32'd0, out_imm32},     {32'd0, e_imm32});
        chk({name, ".fmt32"}, {61'd0, out_fmt32},     {61'd0, e_fmt32});
        chk({name, ".ill32"}, {63'd0, out_illegal32}, {63'd0, e_ill32});
        chk({name, ".tag32"}, {56'd0, out_tag32},     {56'd0, tag});
        chk({name, ".v64"},   {63'd0, out_valid64},   64'd1);
        chk({name, ".imm64"}, out_imm64,              e_imm64);
        chk({name, ".fmt64"}, {61'd0, out_fmt64},     {61'd0, e_fmt64});
        chk({name, ".ill64"}, {63'd0, out_illegal64}, {63'd0, e_ill64});
        chk({name, ".tag64"}, {56'd0, out_tag64},     {56'd0, tag});
    endtask

    task automatic push_no_ready(input logic [31:0] instr, input logic [7:0] tag);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_tag    = tag;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_tag = 8'd0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst.v32",   {63'd0, out_valid32}, 64'd0);
        chk("rst.rdy32", {63'd0, in_ready32},  64'd1);
        chk("rst.imm32", {32'd0, out_imm32},   64'd0);
        chk("rst.fmt32", {61'd0, out_fmt32},   64'd0);
        chk("rst.ill32", {63'd0, out_illegal32}, 64'd0);
        chk("rst.tag32", {56'd0, out_tag32},   64'd0);
        chk("rst.v64",   {63'd0, out_valid64}, 64'd0);
        chk("rst.imm64", out_imm64,            64'd0);
        chk("rst.rdy64", {63'd0, in_ready64},  64'd1);

        // Back-to-back decode vectors (also exercises 1/cycle throughput)
        send_chk("addi",  32'hFFF00093, 8'h10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, I, I, 1'b0, 1'b0);
        send_chk("beq",   32'hFE000EE3, 8'h11, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, B, B, 1'b0, 1'b0);
        send_chk("jal",   32'h0080006F, 8'h12, 32'h00000008, 64'h0000000000000008, J, J, 1'b0, 1'b0);
        send_chk("lui",   32'h800000B7, 8'h13, 32'h80000000, 64'hFFFFFFFF80000000, U, U, 1'b0, 1'b0);
        send_chk("addiw", 32'h0050009B, 8'h14, 32'h00000000, 64'h0000000000000005, R, I, 1'b1, 1'b0);
        send_chk("sw",    32'hFE20AC23, 8'h15, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, S, S, 1'b0, 1'b0);
        send_chk("csrwi", 32'h3002D073, 8'h16, 32'h00000005, 64'h0000000000000005, Z, Z, 1'b0, 1'b0);
        send_chk("csrw",  32'h800010F3, 8'h17, 32'h00000800, 64'h0000000000000800, I, I, 1'b0, 1'b0);
        send_chk("add",   32'h003100B3, 8'h18, 32'h00000000, 64'h0000000000000000, R, R, 1'b0, 1'b0);
        send_chk("bad",   32'hFFFFFFFF, 8'h19, 32'h00000000, 64'h0000000000000000, R, R, 1'b1, 1'b1);
`ifdef IMMGEN_FP_EN
        send_chk("flw",   32'h01012087, 8'h1A, 32'h00000010, 64'h0000000000000010, I, I, 1'b0, 1'b0);
`else
        send_chk("flw",   32'h01012087, 8'h1A, 32'h00000000, 64'h0000000000000000, R, R, 1'b1, 1'b1);
`endif

        // Drain, then backpressure with two entries
        out_ready = 1'b1;
        step();
        chk("drain.v32", {63'd0, out_valid32}, 64'd0);
        push_no_ready(32'h00100093, 8'd1);
        chk("bp1.v32",   {63'd0, out_valid32}, 64'd1);
        chk("bp1.rdy32", {63'd0, in_ready32},  64'd1);
        push_no_ready(32'h00200093, 8'd2);
        chk("bp2.rdy32", {63'd0, in_ready32},  64'd0);
        chk("bp2.rdy64", {63'd0, in_ready64},  64'd0);
        chk("bp2.tag32", {56'd0, out_tag32},   64'd1);
        step();
        chk("bphold.tag32", {56'd0, out_tag32}, 64'd1);
        chk("bphold.imm32", {32'd0, out_imm32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bpout2.v32",   {63'd0, out_valid32}, 64'd1);
        chk("bpout2.tag32", {56'd0, out_tag32},   64'd2);
        chk("bpout2.imm32", {32'd0, out_imm32},   64'd2);
        chk("bpout2.tag64", {56'd0, out_tag64},   64'd2);
        chk("bpout2.rdy32", {63'd0, in_ready32},  64'd1);
        step();
        chk("bpdone.v32",   {63'd0, out_valid32}, 64'd0);

        // Flush with output and skid full
        push_no_ready(32'h00300093, 8'd3);
        push_no_ready(32'h00400093, 8'd4);
        chk("fl.pre.rdy32", {63'd0, in_ready32}, 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl.v32",   {63'd0, out_valid32}, 64'd0);
        chk("fl.v64",   {63'd0, out_valid64}, 64'd0);
        chk("fl.rdy32", {63'd0, in_ready32},  64'd1);
        out_ready = 1'b1;
        step();
        chk("fl.stay.v32", {63'd0, out_valid32}, 64'd0);

        // Input in the flush cycle is dropped
        flush = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 8'd5;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fldrop.v32", {63'd0, out_valid32}, 64'd0);
        send_chk("post", 32'h00600093, 8'd6, 32'h00000006, 64'h0000000000000006, I, I, 1'b0, 1'b0);

        // Reset mid-transfer
        push_no_ready(32'h00700093, 8'd7);
        push_no_ready(32'h00800093, 8'd8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst.v32",   {63'd0, out_valid32}, 64'd0);
        chk("mrst.tag32", {56'd0, out_tag32},   64'd0);
        chk("mrst.imm32", {32'd0, out_imm32},   64'd0);
        chk("mrst.rdy32", {63'd0, in_ready32},  64'd1);
        out_ready = 1'b1;
        step();
        chk("mrst.after.v32", {63'd0, out_valid32}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Registered, parametrised successor to the combinational immediate generator in the decode path.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Produces the sign- or zero-extended immediate at XLEN width, a format code and an illegal-opcode flag, one cycle later.
- A 2-entry skid buffer breaks the ready path between fetch and the execute-side consumer. Supports pipeline flush on branch redirect.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 8, width of opaque sideband tag (PC index/ROB id) carried alongside each instruction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries this cycle
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept
- in_instr  in  32  raw instruction
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  format code (imm_fmt_t)
- out_illegal  out  1  opcode not recognised
- out_tag  out  TAG_W  tag of out_imm's instruction

Behaviour:
- One clock; reset is synchronous and active-high. On reset: out_valid=0, out_imm=0, out_fmt=FMT_R, out_illegal=0, out_tag=0, skid empty, in_ready=1 from the first cycle after reset.
- Decode by opcode instr[6:0]; all signed formats sign-extend from instr[31] to XLEN:
  - 0010011 OP-IMM, 1100111 JALR, 0000011 LOAD -> FMT_I, imm[11:0]=instr[31:20].
  - 0100011 STORE -> FMT_S, {instr[31:25],instr[11:7]}.
  - 1100011 BRANCH -> FMT_B, {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - 0110111 LUI, 0010111 AUIPC -> FMT_U, {instr[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - 1101111 JAL -> FMT_J, {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - 1110011 SYSTEM with funct3[2]=1 -> FMT_Z, zero-extended instr[19:15].
  - SYSTEM with any other funct3 -> FMT_I, zero-extended instr[31:20] (CSR address).
  - 0110011 OP -> FMT_R, imm=0.
  - 0011011 OP-IMM-32: FMT_I when XLEN=64; illegal when XLEN=32.
  - Any other opcode -> FMT_R, imm=0, out_illegal=1.
- Latency: exactly 1 cycle from in handshake (in_valid&in_ready) to out_valid when output register empty or draining.
- Output register holds while out_valid & !out_ready; out_* stable until accepted.
- Skid register:
  - Captures an accepted input when the output register is full and stalled.
  - in_ready = !skid_valid, registered. No combinational path from out_ready to in_ready.
  - Order preserved: skid drains to the output register before any new input.
- Simultaneous accept-in and accept-out with empty skid: output register reloads, no bubble. Full throughput 1/cycle.
- flush: out_valid and skid_valid cleared next edge. An input presented in the same cycle is dropped (in_ready is still asserted, handshake counts as consumed). flush has priority over all loads.
- rst asserted mid-transfer: all buffered entries lost, same as the reset values above.

Optional Feature:
- IMMGEN_FP_EN defined: 0000111 FLOAD -> FMT_I, 0100111 FSTORE -> FMT_S, legal; FMA opcodes 1000011/1000111/1001011/1001111 and 1010011 OP-FP -> FMT_R, legal.
- Undefined: all of these opcodes decode as illegal.

Decomposition:
- Package immgen_pkg holds:
  - imm_fmt_t enum: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6.
  - Opcode localparams OPC_*.
  - function imm_decode(instr, xlen-agnostic) returning {imm, fmt, illegal}.
- One sub-module: immgen_decode, purely combinational, per XLEN. immgen_pipe instantiates it once at the input and registers its result into the skid or output register.

Test Plan:
- XLEN=32, in_instr=32'hFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=32'hFFFFFFFF, out_fmt=FMT_I.
- Branch 32'hFE000EE3 (beq offset -4) -> out_imm=32'hFFFFFFFC, FMT_B. JAL 32'h0080006F -> imm=8, FMT_J.
- XLEN=64, LUI 32'h800000B7 -> out_imm=64'hFFFFFFFF80000000. Same XLEN, OP-IMM-32 legal; at XLEN=32 out_illegal=1, imm=0.
- Backpressure: out_ready=0, send tags 1,2 -> in_ready drops after tag 2. Raise out_ready -> tags 1,2 emerge in order on consecutive cycles, no loss or duplicate.
- flush with output and skid full -> out_valid=0 next cycle, in_ready=1. Later instruction is delivered normally.
- Opcode 0000111 -> out_illegal=1 without IMMGEN_FP_EN; with macro, FMT_I, imm from instr[31:20], illegal=0.
